// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: opcodes, request payload and response states.
package alu_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned ALU_OP_W = 3;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b100;

    typedef struct packed {
        logic [XLEN-1:0]     a;
        logic [XLEN-1:0]     b;
        logic [ALU_OP_W-1:0] op;
    } alu_req_t;

    typedef enum logic {
        RSP_EMPTY,
        RSP_FULL
    } rsp_state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request, shared-ALU and response signals of alu_share_arbiter; slave = arbiter side.
interface alu_share_arbiter_if
    import alu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 2
);

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*XLEN-1:0]     req_a;
    logic [NUM_REQ*XLEN-1:0]     req_b;
    logic [NUM_REQ*ALU_OP_W-1:0] req_op;

    logic [XLEN-1:0]             alu_a;
    logic [XLEN-1:0]             alu_b;
    logic [ALU_OP_W-1:0]         alu_op;
    logic [XLEN-1:0]             alu_result;
    logic                        alu_zero;

    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [ID_W-1:0]             rsp_id;
    logic [XLEN-1:0]             rsp_result;
    logic                        rsp_zero;

    modport slave (
        input  req_valid, req_a, req_b, req_op, alu_result, alu_zero, rsp_ready,
        output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result, rsp_zero
    );

    modport master (
        output req_valid, req_a, req_b, req_op, alu_result, alu_zero, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result, rsp_zero
    );

endinterface

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin pick: first requester at or above i_ptr (with wrap); grant only when enabled.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    always_comb begin
        int unsigned j;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        j       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = (int'(i_ptr) + k) % NUM_REQ;
            if (!o_any && i_req[j]) begin
                o_any = 1'b1;
                o_idx = ID_W'(j);
            end
        end
        // o_idx still names the winner when disabled so the ALU sees its payload
        if (o_any && i_en) begin
            o_grant = NUM_REQ'(1) << o_idx;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external single-cycle ALU between NUM_REQ requesters with a one-entry response slot.
// Optional statistics counters are enabled with macro ALU_ARB_STATS_EN.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    alu_share_arbiter_if.slave      bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]   stat_grant_cnt,
    output logic [15:0]             stat_stall_cnt
`endif
);

    rsp_state_e          r_state;
    rsp_state_e          w_state_nxt;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     w_rr_ptr_nxt;
    logic [ID_W-1:0]     w_idx;
    logic [NUM_REQ-1:0]  w_grant;
    logic                w_any;
    logic                w_slot_free;
    logic                w_accept;
    alu_req_t            w_sel;
    logic [ID_W-1:0]     r_rsp_id;
    logic [XLEN-1:0]     r_rsp_result;
    logic                r_rsp_zero;

    assign w_slot_free = (r_state == RSP_EMPTY) || bus.rsp_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .i_req   (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .i_en    (w_slot_free),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign bus.req_ready = w_grant;
    assign w_accept      = |(bus.req_valid & w_grant);

    always_comb begin
        w_sel = '0;
        if (w_any) begin
            w_sel.a  = bus.req_a[XLEN*w_idx +: XLEN];
            w_sel.b  = bus.req_b[XLEN*w_idx +: XLEN];
            w_sel.op = bus.req_op[ALU_OP_W*w_idx +: ALU_OP_W];
        end
    end

    assign bus.alu_a  = w_sel.a;
    assign bus.alu_b  = w_sel.b;
    assign bus.alu_op = w_sel.op;

    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        unique case (r_state)
            RSP_EMPTY: if (w_accept) w_state_nxt = RSP_FULL;
            RSP_FULL:  if (bus.rsp_ready && !w_accept) w_state_nxt = RSP_EMPTY;
            default:   w_state_nxt = RSP_EMPTY;
        endcase
        if (w_accept) begin
            w_rr_ptr_nxt = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RSP_EMPTY;
            r_rr_ptr     <= '0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            if (w_accept) begin
                r_rsp_id     <= w_idx;
                r_rsp_result <= bus.alu_result;
                r_rsp_zero   <= bus.alu_zero;
            end
        end
    end

    assign bus.rsp_valid  = (r_state == RSP_FULL);
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_zero   = r_rsp_zero;

`ifdef ALU_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] r_grant_cnt;
    logic [15:0]              r_stall_cnt;
    logic                     w_stall;

    assign w_stall = (|bus.req_valid) && !w_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (w_accept && w_grant[i] && (r_grant_cnt[i] != '1)) begin
                    r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
                end
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign stat_grant_cnt = r_grant_cnt;
    assign stat_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter (NUM_REQ=2) with a behavioural ALU on the alu_* ports.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    alu_share_arbiter_if #(.NUM_REQ(2), .ID_W(2)) bus ();

`ifdef ALU_ARB_STATS_EN
    logic [31:0] stat_grant_cnt;
    logic [15:0] stat_stall_cnt;
`endif

    alu_share_arbiter #(.NUM_REQ(2), .ID_W(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus.slave)
`ifdef ALU_ARB_STATS_EN
        ,
        .stat_grant_cnt (stat_grant_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    // external ALU model; undefined opcodes return 0
    logic [31:0] alu_y;
    always_comb begin
        alu_y = 32'd0;
        case (bus.alu_op)
            ALU_ADD: alu_y = bus.alu_a + bus.alu_b;
            ALU_SUB: alu_y = bus.alu_a - bus.alu_b;
            ALU_AND: alu_y = bus.alu_a & bus.alu_b;
            ALU_OR:  alu_y = bus.alu_a | bus.alu_b;
            ALU_SLT: alu_y = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
            default: alu_y = 32'd0;
        endcase
    end
    assign bus.alu_result = alu_y;
    assign bus.alu_zero   = (alu_y == 32'd0);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach its end (got running, expected finished)");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
        bus.req_a[idx*32 +: 32] = a;
        bus.req_b[idx*32 +: 32] = b;
        bus.req_op[idx*3 +: 3]  = op;
    endtask

    task automatic do_reset;
        #2;
        rst_n         = 1'b0;
        bus.req_valid = 2'b00;
        tick;
        rst_n = 1'b1;
    endtask

    initial begin
        n_pass        = 0;
        n_total       = 0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b0;
        tick;
        tick;

        check("rst_valid",  32'(bus.rsp_valid), 32'd0);
        check("rst_id",     32'(bus.rsp_id), 32'd0);
        check("rst_result", bus.rsp_result, 32'd0);
        check("rst_zero",   32'(bus.rsp_zero), 32'd0);
        check("rst_ready",  32'(bus.req_ready), 32'd0);
        check("idle_alu_a", bus.alu_a, 32'd0);
        check("idle_alu_op", 32'(bus.alu_op), 32'd0);
        rst_n = 1'b1;

        // single ADD
        set_req(0, 32'd5, 32'd7, ALU_ADD);
        bus.req_valid = 2'b01;
        bus.rsp_ready = 1'b1;
        #1;
        check("add_ready", 32'(bus.req_ready), 32'd1);
        check("add_alu_a", bus.alu_a, 32'd5);
        tick;
        bus.req_valid = 2'b00;
        check("add_valid",  32'(bus.rsp_valid), 32'd1);
        check("add_id",     32'(bus.rsp_id), 32'd0);
        check("add_result", bus.rsp_result, 32'd12);
        check("add_zero",   32'(bus.rsp_zero), 32'd0);

        // contention from a fresh reset
        do_reset;
        set_req(0, 32'd9, 32'd9, ALU_SUB);
        set_req(1, 32'hFFFF_FFFF, 32'd1, ALU_SLT);
        bus.req_valid = 2'b11;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("cont_grant%0d", k), 32'(bus.req_ready), 32'd1 << (k % 2));
            tick;
            check($sformatf("cont_id%0d", k), 32'(bus.rsp_id), 32'(k % 2));
            check($sformatf("cont_res%0d", k), bus.rsp_result, (k % 2) ? 32'd1 : 32'd0);
            check($sformatf("cont_zero%0d", k), 32'(bus.rsp_zero), (k % 2) ? 32'd0 : 32'd1);
        end

        // backpressure with slot FULL (id=1, result=1); winner req0 still drives the ALU
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp_ready%0d", k), 32'(bus.req_ready), 32'd0);
            check($sformatf("bp_alu_a%0d", k), bus.alu_a, 32'd9);
            tick;
            check($sformatf("bp_valid%0d", k), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("bp_id%0d", k), 32'(bus.rsp_id), 32'd1);
            check($sformatf("bp_res%0d", k), bus.rsp_result, 32'd1);
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_rel_ready", 32'(bus.req_ready), 32'd1);
        tick;
        check("bp_rel_valid", 32'(bus.rsp_valid), 32'd1);
        check("bp_rel_id",    32'(bus.rsp_id), 32'd0);
        check("bp_rel_zero",  32'(bus.rsp_zero), 32'd1);
        bus.req_valid = 2'b00;
        tick;
        check("drain_valid", 32'(bus.rsp_valid), 32'd0);

        // pointer fairness: req1 alone twice, then both -> req0
        set_req(1, 32'h0000_F0F0, 32'h0000_FF00, ALU_AND);
        bus.req_valid = 2'b10;
        for (int k = 0; k < 2; k++) begin
            #1;
            check($sformatf("fair_ready%0d", k), 32'(bus.req_ready), 32'd2);
            tick;
            check($sformatf("fair_id%0d", k), 32'(bus.rsp_id), 32'd1);
            check($sformatf("fair_res%0d", k), bus.rsp_result, 32'h0000_F000);
        end
        bus.req_valid = 2'b11;
        #1;
        check("fair_both_ready", 32'(bus.req_ready), 32'd1);
        tick;
        check("fair_both_id", 32'(bus.rsp_id), 32'd0);
        bus.req_valid = 2'b00;
        tick;

        // asynchronous reset while a response is held
        set_req(0, 32'h0000_00F0, 32'h0000_000F, ALU_OR);
        bus.req_valid = 2'b01;
        bus.rsp_ready = 1'b1;
        tick;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b0;
        check("mid_valid", 32'(bus.rsp_valid), 32'd1);
        check("mid_result", bus.rsp_result, 32'h0000_00FF);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid",  32'(bus.rsp_valid), 32'd0);
        check("mid_rst_result", bus.rsp_result, 32'd0);
        tick;
        rst_n = 1'b1;
        bus.req_valid = 2'b11;
        #1;
        check("mid_ptr_restart", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 2'b10;
        bus.rsp_ready = 1'b1;
        #1;
        check("mid_req1_ready", 32'(bus.req_ready), 32'd2);
        tick;
        check("mid_req1_id", 32'(bus.rsp_id), 32'd1);
        bus.req_valid = 2'b11;
        #1;
        check("mid_both_ready", 32'(bus.req_ready), 32'd1);
        tick;
        check("mid_both_id", 32'(bus.rsp_id), 32'd0);
        bus.req_valid = 2'b00;
        tick;

`ifdef ALU_ARB_STATS_EN
        do_reset;
        check("stat_rst_grant", stat_grant_cnt, 32'd0);
        check("stat_rst_stall", 32'(stat_stall_cnt), 32'd0);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 2'b11;
        repeat (6) tick;
        bus.req_valid = 2'b01;
        repeat (2) tick;
        bus.rsp_ready = 1'b0;
        repeat (4) tick;
        check("stat_grant", stat_grant_cnt, 32'h0003_0005);
        check("stat_stall", 32'(stat_stall_cnt), 32'd4);
        repeat (65535) tick;
        check("stat_stall_sat", 32'(stat_stall_cnt), 32'h0000_FFFF);
        check("stat_grant_hold", stat_grant_cnt, 32'h0003_0005);
        bus.req_valid = 2'b00;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 32-bit single-cycle ALU instance between NUM_REQ requesters, e.g. the execute stage, the branch-compare unit and the address-generation unit.
- Round-robin arbitration uses a valid/ready handshake on each request port.
- The ALU result and zero flag are captured into a one-entry response register tagged with the requester ID.
- Sits between the issue logic and the ALU; the ALU itself is instantiated outside and wired to the alu_* ports.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ID_W, 2, width of the requester ID; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  input  1  system clock, all state updates on its rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
- req_a  input  NUM_REQ*32  operand A per requester; slice i = bits [32*i+31:32*i]
- req_b  input  NUM_REQ*32  operand B per requester
- req_op  input  NUM_REQ*3  ALU op per requester: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT
- alu_a  output  32  operand A driven to the shared ALU
- alu_b  output  32  operand B driven to the shared ALU
- alu_op  output  3  op driven to the shared ALU
- alu_result  input  32  combinational ALU result
- alu_zero  input  1  combinational ALU zero flag
- rsp_valid  output  1  response register holds a result
- rsp_ready  input  1  consumer accepts the response
- rsp_id  output  ID_W  index of the requester that owns the response
- rsp_result  output  32  registered ALU result
- rsp_zero  output  1  registered zero flag

Behaviour:
- Clocking and reset: single clock clk; rst_n is asynchronous and active-low.
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0.
  - Round-robin pointer rr_ptr=0.
  - Response FSM in EMPTY.
- Response FSM: two states, EMPTY and FULL.
  - slot_free = (state==EMPTY) | rsp_ready.
- Arbitration (combinational):
  - Search from index rr_ptr upward with wrap for the first i where req_valid[i]=1.
  - If slot_free, assert req_ready[i] for that i only; otherwise all req_ready=0.
- ALU drive:
  - alu_a/alu_b/alu_op carry the winner's payload whenever any req_valid is set, regardless of slot_free.
  - With no valid request, drive alu_a=0, alu_b=0, alu_op=000.
- Accept (req_valid[i] & req_ready[i]) on edge N:
  - rsp_result<=alu_result, rsp_zero<=alu_zero, rsp_id<=i.
  - rsp_valid=1 from cycle N+1.
  - rr_ptr<=(i+1) mod NUM_REQ.
- Latency: exactly 1 cycle from accept to rsp_valid.
- Throughput: 1 op per cycle while rsp_ready=1.
- Transitions:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on rsp_ready with no accept.
  - FULL -> FULL on rsp_ready with accept; the new result replaces the old in the same edge.
  - FULL with rsp_ready=0: no grant; response outputs held stable.
- rr_ptr is unchanged in any cycle without an accept.
- Requester rules:
  - Keep valid and payload stable until accepted.
  - Valid must not depend on req_ready.
  - req_ready may depend combinationally on req_valid.
- Opcode handling: undefined opcodes are forwarded unchanged; the result is whatever the ALU returns (0 for the current ALU).
- Widths: all data 32-bit; no arithmetic inside this block.
- Reset mid-operation: any held response is dropped (rsp_valid=0) and arbitration restarts at requester 0.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - Adds output stat_grant_cnt (NUM_REQ*16): one 16-bit saturating counter per requester, incremented on each accept by that requester, cleared on reset.
  - Adds output stat_stall_cnt (16): saturating count of cycles where any req_valid=1 and no accept occurred.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package alu_pkg:
  - localparams ALU_ADD..ALU_SLT (3-bit).
  - ALU_OP_W=3, XLEN=32.
  - Typedef alu_req_t {a, b, op}.
  - Enum rsp_state_e {RSP_EMPTY, RSP_FULL}.
- One natural sub-module, rr_arbiter: NUM_REQ-wide round-robin priority pick.
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: one-hot grant, encoded index.

Test Plan (NUM_REQ=2, ALU connected, unless stated):
- Single ADD: req0 a=5, b=7, op=000, rsp_ready=1 -> req_ready[0]=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0.
- Contention after reset: both valid every cycle (req0 SUB 9-9, req1 SLT a=0xFFFFFFFF, b=1), rsp_ready=1:
  - Grants alternate 0,1,0,1.
  - req0 responses: result=0, zero=1.
  - req1 responses: result=1, zero=0.
- Backpressure:
  - rsp_ready=0 for 3 cycles with response FULL -> all req_ready=0; rsp_result/rsp_id held.
  - On rsp_ready=1 -> new accept in that same cycle; next response valid the following cycle.
- Pointer fairness: only req1 valid for 2 ops, then both valid -> req0 granted first (rr_ptr=0 after req1's grant).
- Reset mid-operation: rsp_valid=1 holding OR 0xF0|0x0F, assert rst_n=0 asynchronously mid-cycle -> rsp_valid=0 immediately; after release req1 alone is granted, and with both valid req0 wins.
- ALU_ARB_STATS_EN: 5 req0 grants, 3 req1 grants, 4 stall cycles -> stat_grant_cnt={3,5} (req1 in the upper slice), stat_stall_cnt=4; saturation holds at 0xFFFF.
